dbus_amo_slave: RTL and testbench

Data-bus responder that terminates core load/store/atomic requests on a word-organised local memory and executes atomic memory operations next to the storage. It sits on the data-memory side of the core's dbus and answers with a single-cycle ack pulse. It also executes LR/SC itself using a single-entry reservation register. This lets cores issue one request per atomic instead of a separate load and store.

---
 rtl/dbus_amo_slave.sv | 181 ++++++++++++++++++
 tb/tb_dbus_amo_slave.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dbus_amo_slave.sv
// Data-bus responder on a word-organised local memory, with near-memory AMOs and LR/SC.
// Build macro DBUS_AMO_EN enables LR/SC/AMO (ops 2-12); without it those ops answer with err_o.
module dbus_amo_slave #(
   parameter int DEPTH = 1024
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_i,
   input  logic [3:0]  op_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   input  logic [3:0]  sel_i,
   output logic        ack_o,
   output logic [31:0] rdata_o,
   output logic        err_o
);
   localparam int AW = $clog2(DEPTH);

   localparam logic [3:0] OP_LOAD  = 4'd0;
   localparam logic [3:0] OP_STORE = 4'd1;
`ifdef DBUS_AMO_EN
   localparam logic [3:0] OP_LR   = 4'd2;
   localparam logic [3:0] OP_SC   = 4'd3;
   localparam logic [3:0] OP_SWAP = 4'd4;
   localparam logic [3:0] OP_ADD  = 4'd5;
   localparam logic [3:0] OP_XOR  = 4'd6;
   localparam logic [3:0] OP_AND  = 4'd7;
   localparam logic [3:0] OP_OR   = 4'd8;
   localparam logic [3:0] OP_MIN  = 4'd9;
   localparam logic [3:0] OP_MAX  = 4'd10;
   localparam logic [3:0] OP_MINU = 4'd11;
   localparam logic [3:0] OP_MAXU = 4'd12;

   typedef enum logic [1:0] {IDLE, ACCESS, WRITE} state_t;
`else
   typedef enum logic [1:0] {IDLE, ACCESS} state_t;
`endif

   state_t        state, state_nxt;
   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] idx;
   logic [31:0]   mem_rd;
   logic [31:0]   mem_wd;
   logic [3:0]    mem_be;
   logic          bad;

   assign idx    = addr_i[AW+1:2];
   assign mem_rd = mem[idx];

   // Anything at or beyond 4*DEPTH has a nonzero bit above the word index.
   always_comb begin
      bad = ((addr_i >> (AW + 2)) != 32'd0) || (op_i > 4'd12) ||
            ((op_i >= 4'd2) && (addr_i[1:0] != 2'b00));
`ifndef DBUS_AMO_EN
      bad = bad || (op_i >= 4'd2);
`endif
   end

`ifdef DBUS_AMO_EN
   logic [31:0]   opnd;
   logic [31:0]   amo_res;
   logic          resv_vld;
   logic [AW-1:0] resv_idx;
   logic          resv_set;
   logic          resv_clr;
   logic          resv_hit;

   assign resv_hit = resv_vld && (resv_idx == idx);

   // Ties keep the old memory value (a).
   always_comb begin
      case (op_i)
         OP_SWAP: amo_res = wdata_i;
         OP_ADD:  amo_res = opnd + wdata_i;
         OP_XOR:  amo_res = opnd ^ wdata_i;
         OP_AND:  amo_res = opnd & wdata_i;
         OP_OR:   amo_res = opnd | wdata_i;
         OP_MIN:  amo_res = ($signed(opnd) <= $signed(wdata_i)) ? opnd : wdata_i;
         OP_MAX:  amo_res = ($signed(opnd) >= $signed(wdata_i)) ? opnd : wdata_i;
         OP_MINU: amo_res = (opnd <= wdata_i) ? opnd : wdata_i;
         OP_MAXU: amo_res = (opnd >= wdata_i) ? opnd : wdata_i;
         default: amo_res = wdata_i;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         opnd <= '0;
      else if (state == ACCESS)
         opnd <= mem_rd;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         resv_vld <= 1'b0;
         resv_idx <= '0;
      end else if (resv_set) begin
         resv_vld <= 1'b1;
         resv_idx <= idx;
      end else if (resv_clr) begin
         resv_vld <= 1'b0;
      end
   end
`endif

   always_comb begin
      state_nxt = state;
      ack_o     = 1'b0;
      err_o     = 1'b0;
      rdata_o   = '0;
      mem_be    = '0;
      mem_wd    = wdata_i;
`ifdef DBUS_AMO_EN
      resv_set  = 1'b0;
      resv_clr  = 1'b0;
`endif
      case (state)
         IDLE: if (req_i) state_nxt = ACCESS;
         ACCESS: begin
            state_nxt = IDLE;
            ack_o     = 1'b1;
            if (bad) begin
               err_o = 1'b1;
            end else begin
               case (op_i)
                  OP_LOAD: rdata_o = mem_rd;
                  OP_STORE: begin
                     mem_be = sel_i;
`ifdef DBUS_AMO_EN
                     // A sel_i=0 store writes nothing, so it leaves the reservation alone.
                     resv_clr = resv_hit && (sel_i != 4'b0000);
`endif
                  end
`ifdef DBUS_AMO_EN
                  OP_LR: begin
                     rdata_o  = mem_rd;
                     resv_set = 1'b1;
                  end
                  OP_SC: begin
                     rdata_o  = {31'b0, ~resv_hit};
                     mem_be   = resv_hit ? 4'hf : 4'h0;
                     resv_clr = 1'b1;
                  end
                  default: begin
                     ack_o     = 1'b0;
                     state_nxt = WRITE;
                  end
`else
                  default: ;
`endif
               endcase
            end
         end
`ifdef DBUS_AMO_EN
         WRITE: begin
            state_nxt = IDLE;
            ack_o     = 1'b1;
            rdata_o   = opnd;
            mem_wd    = amo_res;
            mem_be    = 4'hf;
            resv_clr  = resv_hit;
         end
`endif
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   // Storage is not reset; an async reset forces IDLE so mem_be drops before the next edge.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (mem_be[b]) mem[idx][8*b +: 8] <= mem_wd[8*b +: 8];
   end

endmodule

// File: tb/tb_dbus_amo_slave.sv
// Randomised bench for dbus_amo_slave against a transaction-level memory/reservation model.
// Follows the DUT build: DBUS_AMO_EN selects whether ops 2-12 are expected to work.
module tb_dbus_amo_slave;
   localparam int DEPTH = 64;
`ifdef DBUS_AMO_EN
   localparam bit AMO_EN = 1'b1;
`else
   localparam bit AMO_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        req = 1'b0;
   logic [3:0]  op = '0;
   logic [31:0] addr = '0;
   logic [31:0] wdata = '0;
   logic [3:0]  sel = '0;
   logic        ack, err;
   logic [31:0] rdata;

   dbus_amo_slave #(.DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .req_i(req), .op_i(op), .addr_i(addr),
      .wdata_i(wdata), .sel_i(sel), .ack_o(ack), .rdata_o(rdata), .err_o(err)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   logic [31:0] m_mem [DEPTH];
   bit          m_rv = 1'b0;
   int          m_ridx = 0;

   bit          chk_en = 1'b0;
   bit          exp_ack = 1'b0;
   bit          exp_err = 1'b0;
   logic [31:0] exp_rd = '0;
   bit          lit_en = 1'b0;
   logic [31:0] lit_val = '0;

   always @(negedge clk) begin
      if (chk_en) begin
         n_tests++;
         if (ack !== exp_ack || err !== exp_err) begin
            n_fail++;
            $display("FAIL ack_err t=%0t op=%0d addr=%h: got ack=%b err=%b, want ack=%b err=%b",
                     $time, op, addr, ack, err, exp_ack, exp_err);
         end
         if (!rst_n) begin
            n_tests++;
            if (rdata !== 32'h0) begin
               n_fail++;
               $display("FAIL reset_rdata: got %h, want 00000000", rdata);
            end
         end
         if (exp_ack && !exp_err) begin
            n_tests++;
            if (rdata !== exp_rd) begin
               n_fail++;
               $display("FAIL rdata t=%0t op=%0d addr=%h: got %h, want %h", $time, op, addr, rdata, exp_rd);
            end
            if (lit_en) begin
               n_tests++;
               if (rdata !== lit_val) begin
                  n_fail++;
                  $display("FAIL literal t=%0t op=%0d addr=%h: got %h, want %h", $time, op, addr, rdata, lit_val);
               end
            end
         end
      end
   end

   function automatic logic [31:0] amo_f(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
      case (o)
         4'd4:  return b;
         4'd5:  return a + b;
         4'd6:  return a ^ b;
         4'd7:  return a & b;
         4'd8:  return a | b;
         4'd9:  return ($signed(a) > $signed(b)) ? b : a;
         4'd10: return ($signed(a) < $signed(b)) ? b : a;
         4'd11: return (a > b) ? b : a;
         4'd12: return (a < b) ? b : a;
         default: return a;
      endcase
   endfunction

   // Applies one request to the model; returns the response and ack latency.
   task automatic model(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, output bit e, output logic [31:0] r, output int lat);
      int w;
      logic [31:0] old;
      bit pass;
      e = (a >= 32'(4*DEPTH)) || (o > 4'd12) || (o >= 4'd2 && a[1:0] != 2'b00) ||
          (!AMO_EN && o >= 4'd2);
      r = '0;
      lat = 1;
      if (e) return;
      w = int'(a >> 2);
      old = m_mem[w];
      case (o)
         4'd0: r = old;
         4'd1: begin
            for (int b = 0; b < 4; b++)
               if (s[b]) m_mem[w][8*b +: 8] = d[8*b +: 8];
            if (s != 4'd0 && m_rv && m_ridx == w) m_rv = 1'b0;
         end
         4'd2: begin
            r = old;
            m_rv = 1'b1;
            m_ridx = w;
         end
         4'd3: begin
            pass = m_rv && (m_ridx == w);
            r = pass ? 32'd0 : 32'd1;
            if (pass) m_mem[w] = d;
            m_rv = 1'b0;
         end
         default: begin
            lat = 2;
            r = old;
            m_mem[w] = amo_f(o, old, d);
            if (m_rv && m_ridx == w) m_rv = 1'b0;
         end
      endcase
   endtask

   task automatic do_req(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] s, input bit ul, input logic [31:0] lv);
      bit e;
      logic [31:0] r;
      int lat;
      op = o; addr = a; wdata = d; sel = s; req = 1'b1;
      model(o, a, d, s, e, r, lat);
      exp_ack = 1'b0; exp_err = 1'b0; lit_en = 1'b0;
      @(posedge clk); #1;
      if (lat == 2) begin
         @(posedge clk); #1;
      end
      exp_ack = 1'b1; exp_err = e; exp_rd = r; lit_en = ul; lit_val = lv;
      @(posedge clk); #1;
      exp_ack = 1'b0; exp_err = 1'b0; lit_en = 1'b0; req = 1'b0;
   endtask

   task automatic rq(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      do_req(o, a, d, s, 1'b0, 32'h0);
   endtask

   task automatic rql(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [31:0] lv);
      do_req(o, a, d, s, 1'b1, lv);
   endtask

   // Issue a request and pull reset 'cyc' cycles after it is first seen; nothing may commit.
   task automatic abort_req(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d, input int cyc);
      op = o; addr = a; wdata = d; sel = 4'hf; req = 1'b1;
      exp_ack = 1'b0; exp_err = 1'b0;
      repeat (cyc) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0; req = 1'b0; m_rv = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   initial begin
      logic [3:0]  o, s;
      logic [31:0] a, d;
      int k;
      chk_en = 1'b1;
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      for (int w = 0; w < DEPTH; w++) rq(4'd1, 32'(4*w), $urandom, 4'hf);

      rql(4'd0, 32'h10, 32'h0, 4'h0, m_mem[4]);
      rq(4'd1, 32'h10, 32'h11223344, 4'hf);
      rql(4'd0, 32'h10, 32'h0, 4'h0, 32'h11223344);
      rq(4'd1, 32'h10, 32'hDEADBEEF, 4'b0011);
      rql(4'd0, 32'h10, 32'h0, 4'h0, 32'h1122BEEF);
      rq(4'd1, 32'h14, 32'h12345678, 4'h0);
      rq(4'd0, 32'h14, 32'h0, 4'h0);

`ifdef DBUS_AMO_EN
      rq(4'd1, 32'h20, 32'hFFFFFFFE, 4'hf);
      rql(4'd5, 32'h20, 32'd3, 4'h0, 32'hFFFFFFFE);
      rql(4'd0, 32'h20, 32'h0, 4'h0, 32'h00000001);
      rq(4'd1, 32'h20, 32'hFFFFFFFF, 4'hf);
      rql(4'd9, 32'h20, 32'd5, 4'h0, 32'hFFFFFFFF);
      rql(4'd0, 32'h20, 32'h0, 4'h0, 32'hFFFFFFFF);
      rq(4'd12, 32'h20, 32'd5, 4'h0);
      rql(4'd0, 32'h20, 32'h0, 4'h0, 32'hFFFFFFFF);

      rq(4'd2, 32'h40, 32'h0, 4'h0);
      rql(4'd3, 32'h40, 32'hA5, 4'h0, 32'd0);
      rql(4'd0, 32'h40, 32'h0, 4'h0, 32'hA5);
      rql(4'd3, 32'h40, 32'h5A, 4'h0, 32'd1);
      rql(4'd0, 32'h40, 32'h0, 4'h0, 32'hA5);
      rq(4'd2, 32'h40, 32'h0, 4'h0);
      rq(4'd1, 32'h40, 32'h77, 4'b0001);
      rql(4'd3, 32'h40, 32'h66, 4'h0, 32'd1);
      rq(4'd2, 32'h40, 32'h0, 4'h0);
      rq(4'd1, 32'h44, 32'h99, 4'hf);
      rql(4'd3, 32'h40, 32'h66, 4'h0, 32'd0);

      rq(4'd4, 32'h42, 32'h1, 4'h0);
      abort_req(4'd5, 32'h20, 32'd1, 2);
      rql(4'd0, 32'h20, 32'h0, 4'h0, 32'hFFFFFFFF);
      rq(4'd2, 32'h48, 32'h0, 4'h0);
      abort_req(4'd0, 32'h48, 32'h0, 1);
      rql(4'd3, 32'h48, 32'h1, 4'h0, 32'd1);
`else
      rq(4'd2, 32'h40, 32'h0, 4'h0);
      rq(4'd5, 32'h20, 32'd3, 4'h0);
`endif
      rq(4'd14, 32'h40, 32'h1, 4'hf);
      rq(4'd0, 32'(4*DEPTH), 32'h0, 4'h0);
      rq(4'd0, 32'h40, 32'h0, 4'h0);
      rq(4'd1, 32'h30, 32'hCAFEF00D, 4'hf);
      abort_req(4'd1, 32'h30, 32'h0BADBAD0, 1);
      rql(4'd0, 32'h30, 32'h0, 4'h0, 32'hCAFEF00D);

      for (int i = 0; i < 600; i++) begin
         o = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
         a = 32'($urandom_range(0, 15)) * 32'd4;
         k = $urandom_range(0, 19);
         if (k == 0) a = 32'(4*DEPTH) + 32'($urandom_range(0, 63));
         else if (k == 1) a = a + 32'($urandom_range(1, 3));
         else if (k == 2) a = $urandom;
         else if (k == 3) a = 32'($urandom_range(0, DEPTH-1)) * 32'd4;
         d = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 7)) - 32'd4 : $urandom;
         s = 4'($urandom_range(1, 15));
         rq(o, a, d, s);
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
      end

      for (int w = 0; w < 16; w++) rq(4'd0, 32'(4*w), 32'h0, 4'h0);

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
